// File: rtl/sort_engine.sv
// Iterative odd-even transposition sorter: one compare-exchange phase per clock,
// returning sorted keys with their original index tags.
module sort_engine #(
  parameter int unsigned N          = 6,
  parameter int unsigned W          = 10,
  parameter int unsigned IW         = $clog2(N),
  parameter int unsigned PW         = $clog2(N + 1),
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [N*W-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N*IW-1:0] out_idx,
  output logic [PW-1:0]   out_phases
);

  typedef enum logic [1:0] {StIdle, StSort, StDone} state_e;

  state_e               state_q, state_d;
  logic [N-1:0][W-1:0]  key_q, key_d, key_ph;
  logic [N-1:0][IW-1:0] idx_q, idx_d, idx_ph;
  logic                 mode_q, mode_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic                 zero_q, zero_d;
  logic [N-1:0][W-1:0]  res_key_q, res_key_d;
  logic [N-1:0][IW-1:0] res_idx_q, res_idx_d;
  logic [PW-1:0]        res_ph_q, res_ph_d;
  logic                 any_swap;
  logic                 finish;

  // One phase: pairs are disjoint, so every compare reads the registered array.
  always_comb begin
    key_ph   = key_q;
    idx_ph   = idx_q;
    any_swap = 1'b0;
    for (int i = 0; i < int'(N) - 1; i++) begin
      if ((i % 2) == int'(phase_q[0])) begin
        if (mode_q ? (key_q[i] > key_q[i+1]) : (key_q[i] < key_q[i+1])) begin
          key_ph[i]   = key_q[i+1];
          key_ph[i+1] = key_q[i];
          idx_ph[i]   = idx_q[i+1];
          idx_ph[i+1] = idx_q[i];
          any_swap    = 1'b1;
        end
      end
    end
  end

  // zero_q records that the previous phase swapped nothing.
  assign finish = (phase_q == PW'(N - 1)) || ((EARLY_EXIT != 0) && !any_swap && zero_q);

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    phase_d   = phase_q;
    zero_d    = zero_q;
    res_key_d = res_key_q;
    res_idx_d = res_idx_q;
    res_ph_d  = res_ph_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          key_d = in_data;
          for (int k = 0; k < int'(N); k++) begin
            idx_d[k] = IW'(k);
          end
          mode_d  = in_mode;
          phase_d = '0;
          zero_d  = 1'b0;
          state_d = StSort;
        end
      end
      StSort: begin
        key_d   = key_ph;
        idx_d   = idx_ph;
        phase_d = phase_q + PW'(1);
        zero_d  = !any_swap;
        if (finish) begin
          res_key_d = key_ph;
          res_idx_d = idx_ph;
          res_ph_d  = phase_q + PW'(1);
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      key_q     <= '0;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      phase_q   <= '0;
      zero_q    <= 1'b0;
      res_key_q <= '0;
      res_idx_q <= '0;
      res_ph_q  <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      phase_q   <= phase_d;
      zero_q    <= zero_d;
      res_key_q <= res_key_d;
      res_idx_q <= res_idx_d;
      res_ph_q  <= res_ph_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_data   = res_key_q;
  assign out_idx    = res_idx_q;
  assign out_phases = res_ph_q;

endmodule

// File: tb/tb_sort_engine.sv
// Directed bench for sort_engine: sorting scenarios, early exit, backpressure and
// mid-job reset, with hand-computed expected results.
module tb_sort_engine;

  localparam int N  = 6;
  localparam int W  = 10;
  localparam int IW = 3;
  localparam int PW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid, in_mode, out_ready;
  logic [N*W-1:0]  in_data;
  logic            in_ready, out_valid;
  logic [N*W-1:0]  out_data;
  logic [N*IW-1:0] out_idx;
  logic [PW-1:0]   out_phases;

  logic            in_valid2, out_ready2;
  logic            in_ready2, out_valid2;
  logic [N*W-1:0]  out_data2;
  logic [N*IW-1:0] out_idx2;
  logic [PW-1:0]   out_phases2;

  int compared   = 0;
  int mismatched = 0;

  sort_engine #(.N(N), .W(W), .EARLY_EXIT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_phases (out_phases)
  );

  sort_engine #(.N(N), .W(W), .EARLY_EXIT(0)) dut_full (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid2),
    .in_ready   (in_ready2),
    .in_mode    (in_mode),
    .in_data    (in_data),
    .out_valid  (out_valid2),
    .out_ready  (out_ready2),
    .out_data   (out_data2),
    .out_idx    (out_idx2),
    .out_phases (out_phases2)
  );

  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] pk(input int a0, a1, a2, a3, a4, a5);
    pk = {W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic logic [N*IW-1:0] px(input int a0, a1, a2, a3, a4, a5);
    px = {IW'(a5), IW'(a4), IW'(a3), IW'(a2), IW'(a1), IW'(a0)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic mode, input logic [N*W-1:0] data);
    in_mode  = mode;
    in_data  = data;
    check("ready_before_load", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_after_load", {63'd0, in_ready}, 64'd0);
  endtask

  task automatic wait_done(input string tag, input logic [N*W-1:0] exp_d,
                           input logic [N*IW-1:0] exp_i, input int exp_p);
    int cycles;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    check({tag, "_latency"}, 64'(cycles), 64'(exp_p));
    check({tag, "_data"}, 64'(out_data), 64'(exp_d));
    check({tag, "_idx"}, 64'(out_idx), 64'(exp_i));
    check({tag, "_phases"}, 64'(out_phases), 64'(exp_p));
  endtask

  task automatic release_out(input string tag, input logic [N*W-1:0] exp_d);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_fall"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_ready_rise"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_held"}, 64'(out_data), 64'(exp_d));
  endtask

  initial begin
    int cycles;
    in_valid   = 1'b0;
    in_valid2  = 1'b0;
    in_mode    = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    out_ready2 = 1'b0;

    #12;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_idx", 64'(out_idx), 64'd0);
    check("rst_phases", 64'(out_phases), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_ready", {63'd0, in_ready}, 64'd1);

    // Mixed keys with duplicates, descending.
    start_job(1'b0, pk(3, 9, 1, 9, 0, 7));
    wait_done("mix_desc", pk(9, 9, 7, 3, 1, 0), px(1, 3, 5, 0, 2, 4), 5);
    release_out("mix_desc", pk(9, 9, 7, 3, 1, 0));

    // Already sorted: two zero-swap phases end the job.
    start_job(1'b0, pk(9, 8, 7, 6, 5, 4));
    wait_done("sorted", pk(9, 8, 7, 6, 5, 4), px(0, 1, 2, 3, 4, 5), 2);
    release_out("sorted", pk(9, 8, 7, 6, 5, 4));

    // Same input without early exit always runs N phases.
    in_mode   = 1'b0;
    in_data   = pk(9, 8, 7, 6, 5, 4);
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    cycles = 0;
    while (out_valid2 !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    check("full_latency", 64'(cycles), 64'd6);
    check("full_phases", 64'(out_phases2), 64'd6);
    check("full_data", 64'(out_data2), 64'(pk(9, 8, 7, 6, 5, 4)));
    check("full_idx", 64'(out_idx2), 64'(px(0, 1, 2, 3, 4, 5)));
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    check("full_valid_fall", {63'd0, out_valid2}, 64'd0);
    check("full_ready", {63'd0, in_ready2}, 64'd1);

    // All equal, ascending: stability keeps original order.
    start_job(1'b1, pk(5, 5, 5, 5, 5, 5));
    wait_done("equal", pk(5, 5, 5, 5, 5, 5), px(0, 1, 2, 3, 4, 5), 2);
    release_out("equal", pk(5, 5, 5, 5, 5, 5));

    // Worst case descending, then backpressure with ignored load requests.
    start_job(1'b0, pk(0, 1, 2, 3, 4, 5));
    wait_done("worst", pk(5, 4, 3, 2, 1, 0), px(5, 4, 3, 2, 1, 0), 6);
    in_valid = 1'b1;
    in_data  = pk(1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_ready", {63'd0, in_ready}, 64'd0);
      check("bp_data", 64'(out_data), 64'(pk(5, 4, 3, 2, 1, 0)));
      check("bp_idx", 64'(out_idx), 64'(px(5, 4, 3, 2, 1, 0)));
    end
    in_valid = 1'b0;
    release_out("bp", pk(5, 4, 3, 2, 1, 0));

    // Next load after backpressure, ascending with duplicates.
    start_job(1'b1, pk(3, 9, 1, 9, 0, 7));
    wait_done("mix_asc", pk(0, 1, 3, 7, 9, 9), px(4, 2, 0, 5, 1, 3), 6);
    release_out("mix_asc", pk(0, 1, 3, 7, 9, 9));

    // Reset in the middle of a sort job.
    start_job(1'b0, pk(3, 9, 1, 9, 0, 7));
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_idx", 64'(out_idx), 64'd0);
    check("mid_rst_phases", 64'(out_phases), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {63'd0, in_ready}, 64'd1);

    start_job(1'b0, pk(3, 9, 1, 9, 0, 7));
    wait_done("after_rst", pk(9, 9, 7, 3, 1, 0), px(1, 3, 5, 0, 2, 4), 5);
    release_out("after_rst", pk(9, 9, 7, 3, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
